// File: rtl/inst_encoder32_pkg.sv
// Shared types and opcode constants for the RV32I instruction encoder.
package inst_encoder32_pkg;

  typedef enum logic [3:0] {
    KIND_LUI    = 4'd0,
    KIND_AUIPC  = 4'd1,
    KIND_JAL    = 4'd2,
    KIND_JALR   = 4'd3,
    KIND_BRANCH = 4'd4,
    KIND_LOAD   = 4'd5,
    KIND_STORE  = 4'd6,
    KIND_OP_IMM = 4'd7,
    KIND_OP     = 4'd8,
    KIND_FENCE  = 4'd9,
    KIND_ECALL  = 4'd10,
    KIND_EBREAK = 4'd11
  } inst_kind_t;

  // {inst[30], funct3}
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

  typedef struct packed {
    inst_kind_t  kind;
    alu_op_t     alu_op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/inst_encoder32_imm_pack32.sv
// Immediate range check and bit scatter into instruction positions for I/S/B/U/J.
module imm_pack32
  import inst_encoder32_pkg::*;
(
  input  imm_fmt_t    fmt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] imm_bits_o,
  output logic        range_ok_o
);

  logic sext11_ok;
  logic sext12_ok;
  logic sext20_ok;

  assign sext11_ok = (&imm_i[31:11]) || (~|imm_i[31:11]);
  assign sext12_ok = (&imm_i[31:12]) || (~|imm_i[31:12]);
  assign sext20_ok = (&imm_i[31:20]) || (~|imm_i[31:20]);

  always_comb begin
    imm_bits_o = '0;
    range_ok_o = 1'b1;
    case (fmt_i)
      FMT_I: begin
        imm_bits_o[31:20] = imm_i[11:0];
        range_ok_o        = sext11_ok;
      end
      FMT_S: begin
        imm_bits_o[31:25] = imm_i[11:5];
        imm_bits_o[11:7]  = imm_i[4:0];
        range_ok_o        = sext11_ok;
      end
      FMT_B: begin
        imm_bits_o[31]    = imm_i[12];
        imm_bits_o[30:25] = imm_i[10:5];
        imm_bits_o[11:8]  = imm_i[4:1];
        imm_bits_o[7]     = imm_i[11];
        range_ok_o        = sext12_ok && !imm_i[0];
      end
      FMT_U: begin
        imm_bits_o[31:12] = imm_i[31:12];
        range_ok_o        = (imm_i[11:0] == 12'h000);
      end
      FMT_J: begin
        imm_bits_o[31]    = imm_i[20];
        imm_bits_o[30:21] = imm_i[10:1];
        imm_bits_o[20]    = imm_i[11];
        imm_bits_o[19:12] = imm_i[19:12];
        range_ok_o        = sext20_ok && !imm_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder32.sv
// Two-stage RV32I instruction encoder: descriptor in, packed word plus IMEM address out.
module inst_encoder32
  import inst_encoder32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  inst_kind_t  in_kind,
  input  alu_op_t     in_alu_op,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  input  logic        addr_load,
  input  logic [31:0] addr_value,
  output logic [15:0] err_count
);

  logic        s1_valid_q, s1_valid_d;
  desc_t       s1_q, s1_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic        s2_err_q, s2_err_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        s2_adv;
  logic        accept;
  logic        xfer;

  imm_fmt_t    fmt;
  logic [31:0] imm_bits;
  logic        range_ok;
  logic [31:0] base;
  logic        field_ok;
  logic        is_shift;
  logic        enc_err;
  logic [31:0] enc_inst;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;
  assign xfer     = s2_valid_q && out_ready;

  imm_pack32 u_imm_pack (
    .fmt_i      (fmt),
    .imm_i      (s1_q.imm),
    .imm_bits_o (imm_bits),
    .range_ok_o (range_ok)
  );

  // Non-immediate fields per kind; the immediate scatter is OR-ed in afterwards.
  always_comb begin
    fmt      = FMT_NONE;
    base     = '0;
    field_ok = 1'b1;
    is_shift = (s1_q.alu_op[1:0] == 2'b01);
    case (s1_q.kind)
      KIND_LUI: begin
        fmt  = FMT_U;
        base = {20'd0, s1_q.rd, OPC_LUI};
      end
      KIND_AUIPC: begin
        fmt  = FMT_U;
        base = {20'd0, s1_q.rd, OPC_AUIPC};
      end
      KIND_JAL: begin
        fmt  = FMT_J;
        base = {20'd0, s1_q.rd, OPC_JAL};
      end
      KIND_JALR: begin
        fmt  = FMT_I;
        base = {12'd0, s1_q.rs1, 3'b000, s1_q.rd, OPC_JALR};
      end
      KIND_BRANCH: begin
        fmt      = FMT_B;
        base     = {7'd0, s1_q.rs2, s1_q.rs1, s1_q.funct3, 5'd0, OPC_BRANCH};
        field_ok = !(s1_q.funct3 inside {3'b010, 3'b011});
      end
      KIND_LOAD: begin
        fmt      = FMT_I;
        base     = {12'd0, s1_q.rs1, s1_q.funct3, s1_q.rd, OPC_LOAD};
        field_ok = s1_q.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      KIND_STORE: begin
        fmt      = FMT_S;
        base     = {7'd0, s1_q.rs2, s1_q.rs1, s1_q.funct3, 5'd0, OPC_STORE};
        field_ok = s1_q.funct3 inside {3'b000, 3'b001, 3'b010};
      end
      KIND_OP_IMM: begin
        // Shifts reuse the I scatter: with imm[31:5]=0 only shamt lands in [24:20].
        fmt      = FMT_I;
        base     = {1'b0, s1_q.alu_op[3], 10'd0, s1_q.rs1, s1_q.alu_op[2:0], s1_q.rd, OPC_OP_IMM};
        field_ok = (!is_shift || (s1_q.imm[31:5] == 27'd0)) &&
                   (!s1_q.alu_op[3] || (s1_q.alu_op[2:0] == 3'b101));
      end
      KIND_OP: begin
        base     = {1'b0, s1_q.alu_op[3], 5'd0, s1_q.rs2, s1_q.rs1, s1_q.alu_op[2:0], s1_q.rd, OPC_OP};
        field_ok = !s1_q.alu_op[3] || (s1_q.alu_op[2:0] inside {3'b000, 3'b101});
      end
      KIND_FENCE:  base = {s1_q.imm[11:0], 5'd0, 3'b000, 5'd0, OPC_FENCE};
      KIND_ECALL:  base = INST_ECALL;
      KIND_EBREAK: base = INST_EBREAK;
      default:     field_ok = 1'b0;
    endcase
    enc_err  = !(field_ok && range_ok);
    enc_inst = enc_err ? '0 : (base | imm_bits);
  end

  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_d       = accept ? desc_t'{in_kind, in_alu_op, in_funct3, in_rd, in_rs1, in_rs2, in_imm} : s1_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_err_d   = s2_err_q;
    if (s2_adv && s1_valid_q) begin
      s2_inst_d = enc_inst;
      s2_err_d  = enc_err;
    end
    if (addr_load)
      addr_d = addr_value;
    else if (xfer)
      addr_d = addr_q + 32'd4;
    else
      addr_d = addr_q;
    err_cnt_d = err_cnt_q;
    if (xfer && s2_err_q && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_err_q   <= s2_err_d;
      addr_q     <= addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign out_addr  = addr_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder32.sv
// Directed scoreboard bench for inst_encoder32.
module tb_inst_encoder32;
  import inst_encoder32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  inst_kind_t  in_kind;
  alu_op_t     in_alu_op;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic        addr_load;
  logic [31:0] addr_value;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  inst_encoder32 #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_alu_op  (in_alu_op),
    .in_funct3  (in_funct3),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .err_count  (err_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acceptance is sampled at the falling edge so it never races a same-step out_ready change.
  task automatic send(input inst_kind_t k, input alu_op_t a, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] e_inst,
                      input logic [31:0] e_addr, input logic e_err);
    exp_t e;
    logic acc;
    int   n;
    in_valid  = 1'b1;
    in_kind   = k;
    in_alu_op = a;
    in_funct3 = f3;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        e.inst = e_inst;
        e.addr = e_addr;
        e.err  = e_err;
        q.push_back(e);
      end
      tick();
      n++;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no in_ready expected acceptance of %h", e_inst);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h at %h expected no word", out_inst, out_addr);
      end else begin
        e = q.pop_front();
        chk("word_inst", out_inst, e.inst);
        chk("word_addr", out_addr, e.addr);
        chk("word_err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_kind    = KIND_LUI;
    in_alu_op  = ALU_ADD;
    in_funct3  = 3'b000;
    in_rd      = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_imm     = '0;
    out_ready  = 1'b1;
    addr_load  = 1'b0;
    addr_value = '0;
    tick();
    do_reset();

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);

    // ADDI x1,x0,5 : latency two edges after the cycle it is presented
    send(KIND_OP_IMM, ALU_ADD, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 32'd0, 1'b0);
    @(negedge clk);
    chk("latency_not_early", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("latency_arrived", {31'd0, out_valid}, 32'd1);
    tick();
    drain();

    do_reset();
    send(KIND_LUI,    ALU_ADD, 3'b000, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137, 32'd0,  1'b0);
    send(KIND_BRANCH, ALU_ADD, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 32'd4,  1'b0);
    send(KIND_STORE,  ALU_ADD, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8,         32'h0051_2423, 32'd8,  1'b0);
    send(KIND_OP_IMM, ALU_SRA, 3'b000, 5'd3, 5'd3, 5'd0, 32'd4,         32'h4041_D193, 32'd12, 1'b0);

    send(KIND_OP_IMM, ALU_ADD, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 32'd16, 1'b1);
    send(KIND_BRANCH, ALU_ADD, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3,    32'h0, 32'd20, 1'b1);
    drain();
    chk("err_count_two", {16'd0, err_count}, 32'd2);

    // Backpressure: two words fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    send(KIND_OP, ALU_ADD, 3'b000, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 32'd24, 1'b0);
    send(KIND_OP, ALU_SUB, 3'b000, 5'd4, 5'd5, 5'd6, 32'd0, 32'h4062_8233, 32'd28, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    chk("bp_out_inst_held", out_inst, 32'h0031_00B3);
    tick();
    fork
      begin
        send(KIND_LOAD, ALU_ADD, 3'b010, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFFC, 32'hFFC4_2383, 32'd32, 1'b0);
        send(KIND_JAL,  ALU_ADD, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h0010_00EF, 32'd36, 1'b0);
      end
      begin
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stream_no_gap", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();

    // Address reload coinciding with a transfer
    send(KIND_ECALL, ALU_ADD, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0073, 32'd40, 1'b0);
    tick();
    addr_load  = 1'b1;
    addr_value = 32'hFFFF_FFFC;
    tick();
    addr_load  = 1'b0;
    send(KIND_EBREAK, ALU_ADD, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0,      32'h0010_0073, 32'hFFFF_FFFC, 1'b0);
    send(KIND_FENCE,  ALU_ADD, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0FF,    32'h0FF0_000F, 32'h0000_0000, 1'b0);

    send(KIND_BRANCH, ALU_ADD, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0, 32'd4,  1'b1);
    send(inst_kind_t'(4'hF), ALU_ADD, 3'b000, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 32'd8, 1'b1);
    send(KIND_OP,     alu_op_t'(4'b1110), 3'b000, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0, 32'd12, 1'b1);
    send(KIND_OP_IMM, ALU_SRL, 3'b000, 5'd1, 5'd2, 5'd0, 32'd32, 32'h0, 32'd16, 1'b1);
    send(KIND_OP_IMM, ALU_ADD, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 32'd20, 1'b0);
    send(KIND_AUIPC,  ALU_ADD, 3'b000, 5'd5, 5'd0, 5'd0, 32'hFFFF_F000, 32'hFFFF_F297, 32'd24, 1'b0);
    send(KIND_JAL,    ALU_ADD, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 32'h8000_006F, 32'd28, 1'b0);
    drain();
    chk("err_count_six", {16'd0, err_count}, 32'd6);
    chk("addr_after_stream", out_addr, 32'd32);

    // Reset with two words in flight
    out_ready = 1'b0;
    send(KIND_OP_IMM, ALU_ADD, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 32'd32, 1'b0);
    send(KIND_OP_IMM, ALU_ADD, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2, 32'h0020_0093, 32'd36, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_addr", out_addr, 32'd0);
    chk("midrst_err_count", {16'd0, err_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    q.delete();
    out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
